// File: rtl/apb_ram_pkg.sv
// Shared definitions for the APB RAM: transfer FSM state type and helpers
// that derive byte-lane count and word-index shift from the data width.
package apb_ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Wide enough for WAIT_CYCLES-1 with WAIT_CYCLES up to 15.
  localparam int CNT_W = 4;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int index_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_byte_ram.sv
// Word-organised storage with per-byte write enables, a registered read port
// that returns zero when no read is requested, and a synchronous full clear.
module apb_byte_ram
  import apb_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic                clk_i,
  input  logic                clr_i,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [IDX_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int LANES = lane_count(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array and read register; clear wins over any access.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        for (int b = 0; b < LANES; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
        end
      end
      rdata_q <= re_i ? mem_q[addr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_ram_param.sv
// APB slave RAM with optional wait states. Defining APB_RAM_PARAM_WAIT_EN
// builds the WAIT state and its down-counter; otherwise latency is fixed at 1.
module apb_ram_param
  import apb_ram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int SHIFT = index_shift(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << SHIFT) - 64'd1);

  state_e state_q, state_d;
  logic   pready_q, pready_d;
  logic   pslverr_q, pslverr_d;
  logic   access_s;
  logic   enter_done_s;
  logic   err_s;
  logic   ram_we_s, ram_re_s;
  logic [63:0]       index_ext_s;
  logic [DATA_W-1:0] ram_rdata_s;

`ifdef APB_RAM_PARAM_WAIT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign access_s    = psel & penable;
  assign index_ext_s = 64'(paddr) >> SHIFT;
  assign err_s       = (index_ext_s >= 64'(DEPTH)) | (|(paddr & LOW_MASK));

  // State and registered handshake outputs.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q   <= IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

`ifdef APB_RAM_PARAM_WAIT_EN
  // Wait-state down-counter.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Next-state logic; a dropped select during WAIT abandons the transfer.
  always_comb begin
    state_d = state_q;
`ifdef APB_RAM_PARAM_WAIT_EN
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (access_s) begin
`ifdef APB_RAM_PARAM_WAIT_EN
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
`ifdef APB_RAM_PARAM_WAIT_EN
        if (!access_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory effects and response flags are all decided on the edge entering DONE.
  always_comb begin
    enter_done_s = (state_d == DONE);
    pready_d     = enter_done_s;
    pslverr_d    = enter_done_s & err_s;
    ram_we_s     = enter_done_s & pwrite & ~err_s;
    ram_re_s     = enter_done_s & ~pwrite & ~err_s;
  end

  apb_byte_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk_i   (pclk),
    .clr_i   (~presetn),
    .we_i    (ram_we_s),
    .re_i    (ram_re_s),
    .be_i    (pstrb),
    .addr_i  (index_ext_s[IDX_W-1:0]),
    .wdata_i (pwdata),
    .rdata_o (ram_rdata_s)
  );

  assign prdata  = ram_rdata_s;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_ram_param.sv
// Self-checking bench for apb_ram_param against a byte-array reference model.
module tb_apb_ram_param;

  localparam int DEPTH  = 64;
  localparam int NBYTES = DEPTH * 4;
`ifdef APB_RAM_PARAM_WAIT_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 1;
`endif

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0] paddr = 16'h0;
  logic [31:0] pwdata = 32'h0;
  logic [3:0]  pstrb = 4'h0;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int checks = 0;
  int failures = 0;
  byte unsigned ref_mem [NBYTES];

  always #5 pclk = ~pclk;

  apb_ram_param #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(16), .WAIT_CYCLES(3)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  function automatic bit m_err(input logic [15:0] a);
    return (int'(a) >= NBYTES) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (!m_err(a)) begin
      for (int b = 0; b < 4; b++) v[b*8 +: 8] = ref_mem[int'(a) + b];
    end
    return v;
  endfunction

  task automatic m_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    if (!m_err(a)) begin
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[int'(a) + b] = d[b*8 +: 8];
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
  endtask

  // Drives one transfer; entered and left #1 after a rising edge. Returns the
  // response, cycles from the access phase to pready, and whether the cycle
  // after the response is quiet (pready, pslverr, prdata all 0).
  task automatic xfer(input bit wr, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit setup,
                      output logic [31:0] rd, output logic er, output int lat,
                      output bit post_ok);
    psel = 1'b1; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    if (setup) begin
      penable = 1'b0;
      @(posedge pclk); #1;
    end
    penable = 1'b1;
    lat = 0; rd = 32'h0; er = 1'b0;
    while (lat < 40) begin
      @(posedge pclk); #1;
      lat++;
      if (pready) break;
    end
    if (pready) begin
      rd = prdata; er = pslverr;
    end else begin
      lat = -1;
    end
    @(posedge pclk); #1;
    post_ok = (pready === 1'b0) && (pslverr === 1'b0) && (prdata === 32'h0);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    checks++; if (pready !== 1'b0) begin failures++; $display("FAIL reset_pready got=%b exp=0", pready); end
    checks++; if (pslverr !== 1'b0) begin failures++; $display("FAIL reset_pslverr got=%b exp=0", pslverr); end
    checks++; if (prdata !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h exp=0", prdata); end
    m_clear();
    presetn = 1'b1;
    @(posedge pclk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er; int lat; bit post;
    xfer(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 1'b1, rd, er, lat, post);
    m_write(16'h0004, 32'hDEADBEEF, 4'hF);
    checks++; if (lat != LAT) begin failures++; $display("FAIL basic_wr_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL basic_wr_err got=%b exp=0", er); end
    checks++; if (!post) begin failures++; $display("FAIL basic_wr_single_ready got=0 exp=1"); end
    xfer(1'b0, 16'h0004, 32'h0, 4'h0, 1'b1, rd, er, lat, post);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_rd_data got=%h exp=deadbeef", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL basic_rd_err got=%b exp=0", er); end
    checks++; if (lat != LAT) begin failures++; $display("FAIL basic_rd_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (!post) begin failures++; $display("FAIL basic_rd_after_done got=nonzero exp=zero"); end
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic er; int lat; bit post;
    xfer(1'b1, 16'h0008, 32'h11223344, 4'hF, 1'b1, rd, er, lat, post);
    m_write(16'h0008, 32'h11223344, 4'hF);
    xfer(1'b1, 16'h0008, 32'hAABBCCDD, 4'h5, 1'b1, rd, er, lat, post);
    m_write(16'h0008, 32'hAABBCCDD, 4'h5);
    xfer(1'b0, 16'h0008, 32'h0, 4'hF, 1'b1, rd, er, lat, post);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL strobe_merge got=%h exp=11bb33dd", rd); end
    xfer(1'b1, 16'h0008, 32'h99999999, 4'h0, 1'b1, rd, er, lat, post);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL strobe_zero_err got=%b exp=0", er); end
    xfer(1'b0, 16'h0008, 32'h0, 4'h0, 1'b1, rd, er, lat, post);
    checks++; if (rd !== m_read(16'h0008)) begin failures++; $display("FAIL strobe_zero_noop got=%h exp=%h", rd, m_read(16'h0008)); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; bit post;
    xfer(1'b0, 16'h0100, 32'h0, 4'hF, 1'b1, rd, er, lat, post);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_range_flag got=%b exp=1", er); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err_range_data got=%h exp=0", rd); end
    checks++; if (!post) begin failures++; $display("FAIL err_range_after_done got=nonzero exp=zero"); end
    xfer(1'b0, 16'h0002, 32'h0, 4'hF, 1'b1, rd, er, lat, post);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_unaligned_flag got=%b exp=1", er); end
    xfer(1'b1, 16'h0006, 32'hFFFFFFFF, 4'hF, 1'b1, rd, er, lat, post);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_unaligned_wr_flag got=%b exp=1", er); end
    xfer(1'b1, 16'h0100, 32'hFFFFFFFF, 4'hF, 1'b1, rd, er, lat, post);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_range_wr_flag got=%b exp=1", er); end
    xfer(1'b0, 16'h0004, 32'h0, 4'hF, 1'b1, rd, er, lat, post);
    checks++; if (rd !== m_read(16'h0004)) begin failures++; $display("FAIL err_no_write_4 got=%h exp=%h", rd, m_read(16'h0004)); end
    xfer(1'b0, 16'h0000, 32'h0, 4'hF, 1'b1, rd, er, lat, post);
    checks++; if (rd !== m_read(16'h0000)) begin failures++; $display("FAIL err_no_write_0 got=%h exp=%h", rd, m_read(16'h0000)); end
    xfer(1'b0, 16'h00FC, 32'h0, 4'hF, 1'b1, rd, er, lat, post);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL err_last_word_flag got=%b exp=0", er); end
  endtask

  task automatic test_no_select();
    bit seen;
    seen = 1'b0;
    psel = 1'b0; penable = 1'b1; pwrite = 1'b1; paddr = 16'h0010; pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
    repeat (6) begin
      @(posedge pclk); #1;
      if (pready) seen = 1'b1;
    end
    penable = 1'b0;
    checks++; if (seen) begin failures++; $display("FAIL nosel_pready got=1 exp=0"); end
  endtask

`ifdef APB_RAM_PARAM_WAIT_EN
  task automatic test_wait_abort();
    logic [31:0] rd; logic er; int lat; bit post, seen;
    seen = 1'b0;
    psel = 1'b1; pwrite = 1'b1; paddr = 16'h0020; pwdata = 32'hCAFEF00D; pstrb = 4'hF; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    if (pready) seen = 1'b1;
    @(posedge pclk); #1;
    if (pready) seen = 1'b1;
    psel = 1'b0; penable = 1'b0;
    repeat (8) begin
      @(posedge pclk); #1;
      if (pready) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL abort_pready got=1 exp=0"); end
    xfer(1'b0, 16'h0020, 32'h0, 4'hF, 1'b1, rd, er, lat, post);
    checks++; if (rd !== m_read(16'h0020)) begin failures++; $display("FAIL abort_mem got=%h exp=%h", rd, m_read(16'h0020)); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] rd, wd [10]; logic er; int lat; bit post;
    for (int i = 0; i < 10; i++) begin
      wd[i] = $urandom;
      xfer(1'b1, 16'(i * 4), wd[i], 4'hF, (i == 0), rd, er, lat, post);
      m_write(16'(i * 4), wd[i], 4'hF);
      checks++; if (lat != LAT) begin failures++; $display("FAIL b2b_wr_latency idx=%0d got=%0d exp=%0d", i, lat, LAT); end
      checks++; if (!post) begin failures++; $display("FAIL b2b_wr_single_ready idx=%0d got=0 exp=1", i); end
    end
    for (int i = 0; i < 10; i++) begin
      xfer(1'b0, 16'(i * 4), 32'h0, 4'h0, 1'b0, rd, er, lat, post);
      checks++; if (rd !== wd[i]) begin failures++; $display("FAIL b2b_rd_data idx=%0d got=%h exp=%h", i, rd, wd[i]); end
      checks++; if (lat != LAT) begin failures++; $display("FAIL b2b_rd_latency idx=%0d got=%0d exp=%0d", i, lat, LAT); end
      checks++; if (!post) begin failures++; $display("FAIL b2b_rd_single_ready idx=%0d got=0 exp=1", i); end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, d, exp; logic [15:0] a; logic [3:0] s; logic er; bit wr, post; int lat;
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom_range(0, 32'h10F));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      wr = 1'($urandom_range(0, 1));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      exp = m_read(a);
      xfer(wr, a, d, s, 1'b1, rd, er, lat, post);
      checks++; if (er !== m_err(a)) begin failures++; $display("FAIL rand_err addr=%h got=%b exp=%b", a, er, m_err(a)); end
      checks++; if (lat != LAT) begin failures++; $display("FAIL rand_latency addr=%h got=%0d exp=%0d", a, lat, LAT); end
      if (!wr) begin
        checks++; if (rd !== exp) begin failures++; $display("FAIL rand_rd_data addr=%h got=%h exp=%h", a, rd, exp); end
      end
      if (wr) m_write(a, d, s);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; bit post;
    xfer(1'b1, 16'h0010, 32'h12345678, 4'hF, 1'b1, rd, er, lat, post);
    m_write(16'h0010, 32'h12345678, 4'hF);
    psel = 1'b1; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'hA5A5A5A5; pstrb = 4'hF; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
`ifdef APB_RAM_PARAM_WAIT_EN
    @(posedge pclk); #1;
`endif
    presetn = 1'b0;
    @(posedge pclk); #1;
    checks++; if (pready !== 1'b0) begin failures++; $display("FAIL midrst_pready got=%b exp=0", pready); end
    checks++; if (pslverr !== 1'b0) begin failures++; $display("FAIL midrst_pslverr got=%b exp=0", pslverr); end
    checks++; if (prdata !== 32'h0) begin failures++; $display("FAIL midrst_prdata got=%h exp=0", prdata); end
    psel = 1'b0; penable = 1'b0; presetn = 1'b1;
    m_clear();
    @(posedge pclk); #1;
    checks++; if (pready !== 1'b0) begin failures++; $display("FAIL midrst_no_late_ready got=%b exp=0", pready); end
    xfer(1'b0, 16'h0000, 32'h0, 4'hF, 1'b1, rd, er, lat, post);
    checks++; if (rd !== m_read(16'h0000)) begin failures++; $display("FAIL midrst_addr0 got=%h exp=%h", rd, m_read(16'h0000)); end
    xfer(1'b0, 16'h0010, 32'h0, 4'hF, 1'b1, rd, er, lat, post);
    checks++; if (rd !== m_read(16'h0010)) begin failures++; $display("FAIL midrst_clear got=%h exp=%h", rd, m_read(16'h0010)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_errors();
    test_no_select();
`ifdef APB_RAM_PARAM_WAIT_EN
    test_wait_abort();
`endif
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_ram_param.md
APB_RAM_PARAM -- requirements
Module: apb_ram_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter DEPTH, default 64, number of DATA_W-bit words.
REQ-003 SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, extra wait states per access (0..15).
REQ-005 SHALL have port pclk, input, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port presetn, input, 1, reset; one clock; reset is synchronous and active-low.
REQ-007 SHALL have ports psel, penable, pwrite, all input, 1 bit each, with APB meanings.
REQ-008 SHALL have port paddr, input, ADDR_W, byte address.
REQ-009 SHALL have port pwdata, input, DATA_W, write data.
REQ-010 SHALL have port pstrb, input, DATA_W/8, byte write strobes.
REQ-011 SHALL have port prdata, output, DATA_W, registered read data.
REQ-012 SHALL have ports pready and pslverr, output, 1 bit each, both registered.

Function
REQ-013 SHALL use FSM states IDLE, WAIT and DONE.
REQ-014 IDLE: psel&&penable sampled high SHALL go to WAIT when WAIT_CYCLES>0, otherwise to DONE; all other inputs SHALL stay in IDLE.
REQ-015 WAIT SHALL load a down-counter with WAIT_CYCLES-1 on entry and SHALL go to DONE when the counter is 0.
REQ-016 DONE SHALL drive pready=1 for exactly one cycle, then return to IDLE with pready=0.
REQ-017 Latency SHALL be 1+WAIT_CYCLES cycles from the first access-phase cycle to pready high.
REQ-018 The word index SHALL be paddr >> log2(DATA_W/8).
REQ-019 An access SHALL be in error if the index is >= DEPTH or the low log2(DATA_W/8) bits of paddr are nonzero.
REQ-020 Memory update and read capture SHALL occur on the clock edge entering DONE, using paddr/pwrite/pwdata/pstrb sampled at that edge.
REQ-021 A legal write SHALL update only the bytes whose pstrb bit is 1; pstrb=0 SHALL be a legal no-op with pslverr=0.
REQ-022 A legal read SHALL place mem[index] on prdata during DONE; pstrb SHALL be ignored on reads.
REQ-023 An erroneous access SHALL drive pslverr=1 and prdata=0 in DONE and SHALL leave memory unchanged.
REQ-024 prdata SHALL be 0 outside DONE-of-read; pslverr SHALL be 0 outside DONE.
REQ-025 psel or penable low while in WAIT SHALL abort to IDLE with no memory effect and no pready.
REQ-026 Back-to-back transfers SHALL be accepted: a new access phase in the cycle after DONE starts the next transfer from IDLE.

Reset
REQ-027 presetn=0 at a clock edge SHALL force IDLE, pready=0, pslverr=0, prdata=0 and counter=0.
REQ-028 Reset SHALL clear all memory words to 0.
REQ-029 Reset mid-transfer SHALL abandon the transfer without a memory write.

Configuration
REQ-030 Macro APB_RAM_PARAM_WAIT_EN defined SHALL build the WAIT state and counter and SHALL honour WAIT_CYCLES.
REQ-031 Macro APB_RAM_PARAM_WAIT_EN undefined SHALL omit the WAIT state and counter, SHALL ignore WAIT_CYCLES, and SHALL give a fixed latency of 1.

Structure
REQ-032 Package apb_ram_pkg SHALL hold the state enum type (IDLE/WAIT/DONE) and the localparam helpers for byte-lane count and index shift.
REQ-033 The storage SHALL be a sub-module apb_byte_ram with byte-enable write, synchronous read and synchronous clear.

Verification
REQ-034 Reset then write 0xDEADBEEF to 0x0004 with pstrb=0xF, then read 0x0004 -> pready one cycle after the access phase, prdata=0xDEADBEEF, pslverr=0.
REQ-035 Write 0x11223344 to 0x0008, then write 0xAABBCCDD with pstrb=0x5, then read 0x0008 -> prdata=0x11BB33DD.
REQ-036 Read 0x0100 with DEPTH=64 (out of range) -> pslverr=1, prdata=0; read of 0x0002 (unaligned) -> pslverr=1.
REQ-037 With APB_RAM_PARAM_WAIT_EN defined and WAIT_CYCLES=3 -> pready rises 4 cycles after the access phase; dropping psel in the second WAIT cycle -> no pready and memory unchanged.
REQ-038 Assert presetn=0 during WAIT of a write to 0x0000 -> state IDLE, all outputs 0, and a subsequent read of 0x0000 returns 0.
REQ-039 Ten back-to-back writes followed by ten reads over addresses 0x00..0x24 -> every read matches its write, with exactly one pready cycle per transfer.
